bram_stream_reader: RTL and testbench

- Read-side master for bram_sdp: drives the BRAM read port (addr_read/data_out) and converts a block of consecutive words into a valid/ready stream with a last flag.
- Hides the BRAM's 1-cycle synchronous read latency behind a 2-entry output buffer, so it sustains 1 word/cycle under arbitrary backpressure.
- Used to scan simulation grid buffers into downstream compute and display pipelines.

---
 rtl/stream_fifo2.sv | 65 ++++++
 rtl/bram_stream_reader.sv | 133 +++++++++++++
 tb/tb_bram_stream_reader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_fifo2.sv
// stream_fifo2: 2-entry synchronous FIFO carrying a data word and a last flag.
//   clk, rst               clock, synchronous active-high reset
//   push, push_data/last   write side; ignored when full unless popping
//   pop                    read side; ignored when empty
//   head_data/last         oldest entry, held stable until popped
//   empty, full            occupancy flags
module stream_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_last,
  output logic             empty,
  output logic             full
);

  logic [WIDTH:0] slot0;
  logic [WIDTH:0] slot1;
  logic [1:0]     count;
  logic           do_pop;
  logic           do_push;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= {push_last, push_data};
          else               slot1 <= {push_last, push_data};
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= {push_last, push_data};
          end else begin
            slot0 <= slot1;
            slot1 <= {push_last, push_data};
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data = slot0[WIDTH-1:0];
  assign head_last = slot0[WIDTH];
  assign empty     = (count == 2'd0);
  assign full      = (count == 2'd2);

endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads len consecutive BRAM words from base_addr (wrapping
// mod DEPTH) and emits them as a valid/ready stream with m_last on the final word.
//   start/base_addr/len   request, sampled only when idle; len=0 just pulses done
//   busy, done            transfer in progress / one-cycle completion pulse
//   mem_addr, mem_data    BRAM read port (1-cycle read latency)
//   m_data/valid/ready/last  output stream
module bram_stream_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDRW-1:0] base_addr,
  input  logic [ADDRW:0]   len,
  output logic             busy,
  output logic             done,
  output logic [ADDRW-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_data,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDRW:0]   ONE       = 1;
  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);

  state_t         state;
  state_t         state_n;
  logic           done_n;
  logic [ADDRW:0] len_q;
  logic [ADDRW:0] issued;
  logic [ADDRW:0] popped;
  logic           inflight;
  logic           inflight_last;
  logic           fifo_empty;
  logic           fifo_full;
  logic [1:0]     occ;
  logic           pop;
  logic           issue;
  logic           last_issue;
  logic           last_pop;
  logic           accept;

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign busy    = (state != IDLE);
  assign accept  = (state == IDLE) && start && (len != '0);

  // Buffered words plus the read in flight; a new read may only be issued
  // if that total, net of this cycle's pop, leaves room in the 2-entry buffer.
  assign occ        = {fifo_full, !fifo_full && !fifo_empty} + {1'b0, inflight};
  assign issue      = (state == RUN) && (issued < len_q) && (occ < (pop ? 2'd3 : 2'd2));
  assign last_issue = issue && ((issued + ONE) == len_q);
  assign last_pop   = pop && ((popped + ONE) == len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) state_n = RUN;
          else           done_n  = 1'b1;
        end
      end
      RUN: begin
        if (last_issue) state_n = DRAIN;
      end
      DRAIN: begin
        if (last_pop) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q         <= '0;
      issued        <= '0;
      popped        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      mem_addr      <= '0;
    end else begin
      inflight      <= issue;
      inflight_last <= last_issue;
      if (accept) begin
        len_q    <= len;
        issued   <= '0;
        popped   <= '0;
        mem_addr <= base_addr;
      end else begin
        if (issue) begin
          issued   <= issued + ONE;
          mem_addr <= (mem_addr == LAST_ADDR) ? '0 : mem_addr + 1'b1;
        end
        if (pop) popped <= popped + ONE;
      end
    end
  end

  stream_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (mem_data),
    .push_last (inflight_last),
    .pop       (pop),
    .head_data (m_data),
    .head_last (m_last),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 256;
  localparam int ADDRW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [ADDRW-1:0] base_addr;
  logic [ADDRW:0]   len;
  logic             busy;
  logic             done;
  logic [ADDRW-1:0] mem_addr;
  logic [WIDTH-1:0] mem_data;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  logic [WIDTH-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  // bram_sdp read port: registered data one cycle after the address
  always @(posedge clk) mem_data <= mem[mem_addr];

  bram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // scoreboard entries are {last, data}
  logic [WIDTH:0] exp_q [$];
  logic           zero_ok = 1'b0;

  task automatic push_expected(input logic [ADDRW-1:0] b, input int l);
    logic [ADDRW-1:0] a;
    for (int i = 0; i < l; i++) begin
      a = b + ADDRW'(i);
      exp_q.push_back({(i == l - 1), mem[a]});
    end
  endtask

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic do_start(input logic [ADDRW-1:0] b, input logic [ADDRW:0] l);
    push_expected(b, int'(l));
    start     = 1'b1;
    base_addr = b;
    len       = l;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // monitor state
  logic           prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data;
  logic           prev_lastb;
  logic           prev_last_hs = 1'b0;
  logic           prev_busy = 1'b0;
  logic [ADDRW-1:0] prev_addr;
  int             issues = 0;
  int             pops   = 0;
  int             beats  = 0;
  logic [WIDTH:0] e;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
      prev_busy    = 1'b0;
      prev_addr    = mem_addr;
      issues       = 0;
      pops         = 0;
    end else begin
      if (prev_busy && mem_addr != prev_addr) issues++;
      if (busy) check("outstanding_le2", 32'((issues - pops) <= 2), 32'd1);
      check("done_pulse", 32'(done), 32'(prev_last_hs || zero_ok));
      if (prev_last_hs) check("busy_after_done", 32'(busy), 32'd0);
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'(prev_data));
        check("stall_last", 32'(m_last), 32'(prev_lastb));
      end
      prev_last_hs = 1'b0;
      if (m_valid && m_ready) begin
        check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("m_data", 32'(m_data), 32'(e[WIDTH-1:0]));
          check("m_last", 32'(m_last), 32'(e[WIDTH]));
          prev_last_hs = e[WIDTH];
        end
        pops++;
        beats++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_lastb = m_last;
      prev_busy  = busy;
      prev_addr  = mem_addr;
    end
  end

  // wait until idle with an empty scoreboard; optionally random backpressure
  // including a forced 6-cycle stall
  task automatic wait_idle(input bit rand_ready, input int max_cyc);
    bit idle = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      #1;
      if (rand_ready) m_ready = (i >= 10 && i < 16) ? 1'b0 : 1'($urandom_range(0, 1));
      if (!busy && exp_q.size() == 0) begin
        idle = 1'b1;
        break;
      end
    end
    check("wait_idle_timeout", 32'(idle), 32'd1);
    m_ready = 1'b1;
  endtask

  // ready held high; counts negedges from the accepting edge
  task automatic run_measured(input logic [ADDRW-1:0] b, input logic [ADDRW:0] l,
                              output int t_valid, output int t_done);
    int n = 0;
    t_valid = 0;
    t_done  = 0;
    do_start(b, l);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_after_start", 32'(busy), 32'd1);
      if (m_valid && t_valid == 0) t_valid = n;
      if (done) begin
        t_done = n;
        break;
      end
    end
  endtask

  int tv, td, b0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i) ^ 8'h5A;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    m_ready   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // basic transfer: latency and full-rate throughput
    b0 = beats;
    run_measured(8'h10, 9'd4, tv, td);
    check("t1_first_valid_lat", 32'(tv), 32'd3);
    check("t1_done_lat", 32'(td), 32'd7);
    wait_idle(1'b0, 50);
    check("t1_beats", 32'(beats - b0), 32'd4);

    // address wrap-around
    b0 = beats;
    do_start(8'hFE, 9'd4);
    wait_idle(1'b0, 100);
    check("t2_beats", 32'(beats - b0), 32'd4);

    // random backpressure, with a start pulsed while busy
    b0 = beats;
    m_ready = 1'b0;
    do_start(8'h30, 9'd8);
    start     = 1'b1;
    base_addr = 8'h00;
    len       = 9'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle(1'b1, 500);
    check("t3_beats", 32'(beats - b0), 32'd8);

    // len = 0: done only, no beats, never busy
    b0 = beats;
    start     = 1'b1;
    base_addr = 8'h55;
    len       = 9'd0;
    @(posedge clk);
    #1 start = 1'b0;
    zero_ok = 1'b1;
    @(negedge clk);
    check("t4_zero_done", 32'(done), 32'd1);
    check("t4_zero_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 zero_ok = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t4_zero_busy_later", 32'(busy), 32'd0);
    check("t4_beats", 32'(beats - b0), 32'd0);

    // full-depth transfer
    b0 = beats;
    run_measured(8'h80, 9'd256, tv, td);
    check("t5_done_lat", 32'(td), 32'd259);
    wait_idle(1'b0, 50);
    check("t5_beats", 32'(beats - b0), 32'd256);

    // reset with a full buffer and a stalled transfer
    m_ready = 1'b0;
    do_start(8'h40, 9'd8);
    repeat (5) @(posedge clk);
    #1;
    check("t6_full_valid", 32'(m_valid), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6_rst_valid", 32'(m_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 m_ready = 1'b1;

    // fresh transfer after the abort
    b0 = beats;
    do_start(8'hC0, 9'd5);
    wait_idle(1'b0, 100);
    check("t7_beats", 32'(beats - b0), 32'd5);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
